// File: rtl/arp_encode_if.sv
// Handshake bundle between an ARP reply requester/sink and the nibble encoder.
// master = requester and downstream sink side, slave = encoder side.
interface arp_encode_if;
  logic        start;
  logic [47:0] tha;
  logic [31:0] tpa;
  logic        ready;
  logic [3:0]  dout;
  logic        dout_valid;
  logic        busy;
  logic        done;

  modport master (
    output start, tha, tpa, ready,
    input  dout, dout_valid, busy, done
  );

  modport slave (
    input  start, tha, tpa, ready,
    output dout, dout_valid, busy, done
  );
endinterface

// File: rtl/arp_encode.sv
// ARP reply payload serializer: emits the 28-byte reply as 56 nibbles, MS nibble first,
// with a valid/ready handshake toward the downstream framer.
module arp_encode #(
  parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01,
  parameter logic [31:0] LOCAL_IP  = 32'hC0A8_0164
) (
  input  logic         clk,
  input  logic         rst,
  arp_encode_if.slave  bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
  localparam logic [5:0] LAST_IDX = 6'd55;

  logic [0:0]  state_reg, state_next;
  logic [5:0]  idx_reg, idx_next;
  logic [47:0] tha_reg, tha_next;
  logic [31:0] tpa_reg, tpa_next;
  logic [3:0]  dout_reg, dout_next;
  logic        dout_valid_reg, dout_valid_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;

  // Full payload: HTYPE, PTYPE, HLEN, PLEN, OPER=2, SHA, SPA, THA, TPA.
  logic [223:0] frame;
  assign frame = {16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0002,
                  LOCAL_MAC, LOCAL_IP, tha_reg, tpa_reg};

  // Nibble lookup sized to the full 6-bit index range; slots past 55 are never selected.
  logic [3:0] nib [64];
  generate
    for (genvar gi = 0; gi < 64; gi++) begin : g_nib
      if (gi < 56) begin : g_used
        assign nib[gi] = frame[223 - 4*gi -: 4];
      end else begin : g_unused
        assign nib[gi] = 4'h0;
      end
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    tha_next        = tha_reg;
    tpa_next        = tpa_reg;
    dout_next       = dout_reg;
    dout_valid_next = dout_valid_reg;
    busy_next       = busy_reg;
    done_next       = 1'b0;

    case (state_reg)
      IDLE: begin
        dout_next       = 4'h0;
        dout_valid_next = 1'b0;
        busy_next       = 1'b0;
        if (bus.start) begin
          tha_next        = bus.tha;
          tpa_next        = bus.tpa;
          idx_next        = 6'd0;
          state_next      = SEND;
          dout_valid_next = 1'b1;
          busy_next       = 1'b1;
          // Index 0 is part of the constant header, so the old latched fields don't matter.
          dout_next       = nib[6'd0];
        end
      end
      SEND: begin
        if (bus.ready) begin
          if (idx_reg == LAST_IDX) begin
            state_next      = IDLE;
            idx_next        = 6'd0;
            dout_next       = 4'h0;
            dout_valid_next = 1'b0;
            busy_next       = 1'b0;
            done_next       = 1'b1;
          end else begin
            idx_next  = idx_reg + 6'd1;
            dout_next = nib[idx_reg + 6'd1];
          end
        end
      end
      default: begin
        state_next      = IDLE;
        idx_next        = 6'd0;
        dout_next       = 4'h0;
        dout_valid_next = 1'b0;
        busy_next       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      idx_reg        <= 6'd0;
      tha_reg        <= 48'h0;
      tpa_reg        <= 32'h0;
      dout_reg       <= 4'h0;
      dout_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      tha_reg        <= tha_next;
      tpa_reg        <= tpa_next;
      dout_reg       <= dout_next;
      dout_valid_reg <= dout_valid_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
    end
  end

  assign bus.dout       = dout_reg;
  assign bus.dout_valid = dout_valid_reg;
  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;

endmodule

// File: tb/tb_arp_encode.sv
// Scoreboard bench for arp_encode: stimulus pushes hand-written nibble strings,
// a negedge monitor pops and compares at every handshake and done pulse.
module tb_arp_encode;

  localparam logic [47:0] MAC = 48'h02_00_00_00_00_01;
  localparam logic [31:0] IP  = 32'hC0A8_0164;
  localparam int DONE_TOK = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arp_encode_if bus();

  arp_encode #(.LOCAL_MAC(MAC), .LOCAL_IP(IP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int q[$];

  // Header + own SHA/SPA, written out by hand from the field definitions.
  string hdr = "0001080006040002020000000001C0A80164";

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic int hexval(input byte c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
    return 0;
  endfunction

  task automatic push_frame(input string s);
    for (int i = 0; i < s.len(); i++) q.push_back(hexval(s[i]));
    q.push_back(DONE_TOK);
  endtask

  // Monitor: checks nibble order, done pulses, hold-while-stalled, and field recovery.
  logic        hold_pend = 1'b0;
  logic [3:0]  hold_val  = 4'h0;
  logic [223:0] cap = '0;
  int          cap_n = 0;
  int          hs_n = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_pend = 1'b0;
        cap_n = 0;
      end else begin
        if (hold_pend && bus.dout_valid) chk("hold_dout", 64'(bus.dout), 64'(hold_val));
        hold_pend = bus.dout_valid && !bus.ready;
        hold_val  = bus.dout;
        if (bus.done) begin
          if (q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
          else chk("done_order", 64'(q.pop_front()), 64'(DONE_TOK));
          chk("frame_len", 64'(cap_n), 64'd56);
          chk("rx_sha", 64'(cap[159:112]), 64'(MAC));
          chk("rx_spa", 64'(cap[111:80]), 64'(IP));
          chk("rx_hdr", 64'(cap[223:176]), 64'h0001_0800_0604);
          cap_n = 0;
        end
        if (bus.dout_valid && bus.ready) begin
          if (q.size() == 0) chk("unexpected_nibble", 64'd1, 64'd0);
          else chk($sformatf("nibble_%0d", hs_n), 64'(bus.dout), 64'(q.pop_front()));
          cap = {cap[219:0], bus.dout};
          cap_n++;
          hs_n++;
        end
      end
    end
  end

  // Called just after a rising edge: pulses start, then scrambles tha/tpa.
  task automatic issue(input logic [47:0] t_ha, input logic [31:0] t_pa, input string exp_s);
    push_frame(exp_s);
    hs_n = 0;
    bus.start = 1'b1;
    bus.tha   = t_ha;
    bus.tpa   = t_pa;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.tha   = 48'h5A5A_5A5A_5A5A;
    bus.tpa   = 32'hA5A5_A5A5;
    @(negedge clk);
    chk("first_valid", 64'(bus.dout_valid), 64'd1);
    chk("first_busy", 64'(bus.busy), 64'd1);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (!(q.size() == 0 && !bus.busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk("drain_timeout", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    bus.start = 1'b0;
    bus.tha   = '0;
    bus.tpa   = '0;
    bus.ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dout", 64'(bus.dout), 64'd0);
    chk("rst_valid", 64'(bus.dout_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Continuous ready.
    bus.ready = 1'b1;
    issue(48'hAABBCCDDEEFF, 32'hC0A80101, {hdr, "AABBCCDDEEFF", "C0A80101"});
    wait_drain(200);

    // Pseudo-random stalls.
    issue(48'hAABBCCDDEEFF, 32'hC0A80101, {hdr, "AABBCCDDEEFF", "C0A80101"});
    n = 0;
    while (q.size() > 0 && n < 2000) begin
      @(posedge clk); #1;
      bus.ready = 1'($urandom_range(0, 1));
      n++;
    end
    bus.ready = 1'b1;
    wait_drain(200);

    // Start re-pulsed mid-frame with different addresses is ignored.
    issue(48'h112233445566, 32'h0A000002, {hdr, "112233445566", "0A000002"});
    repeat (20) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.tha   = 48'h665544332211;
    bus.tpa   = 32'hDEADBEEF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_drain(200);

    // Reset at index 30 aborts without done; start during reset is ignored.
    issue(48'h0123456789AB, 32'h0A0B0C0D, {hdr, "0123456789AB", "0A0B0C0D"});
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.start = 1'b1;
    bus.tha   = 48'hFEDCBA987654;
    @(posedge clk); #1;
    q.delete();
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk("abort_valid", 64'(bus.dout_valid), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_dout", 64'(bus.dout), 64'd0);
    @(negedge clk);
    chk("abort_no_done", 64'(bus.done), 64'd0);
    chk("abort_idle", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    issue(48'hA1B2C3D4E5F6, 32'hAC100001, {hdr, "A1B2C3D4E5F6", "AC100001"});
    wait_drain(200);

    // Back-to-back: start during the done cycle.
    issue(48'hAABBCCDDEEFF, 32'hC0A80101, {hdr, "AABBCCDDEEFF", "C0A80101"});
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.done && n < 200);
    chk("b2b_done_seen", 64'(bus.done), 64'd1);
    issue(48'h00000000000F, 32'hFFFFFFFF, {hdr, "00000000000F", "FFFFFFFF"});
    wait_drain(200);

    chk("final_queue", 64'(q.size()), 64'd0);
    chk("final_idle", 64'(bus.busy), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/arp_encode.md
ARP_ENCODE -- requirements
Module: arp_encode

Interface
REQ-001 SHALL have parameter LOCAL_MAC, default 48'h02_00_00_00_00_01, own hardware address sent as SHA.
REQ-002 SHALL have parameter LOCAL_IP, default 32'hC0A8_0164, own IPv4 address sent as SPA.
REQ-003 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request to emit one ARP reply payload.
REQ-006 SHALL have port tha  input  48  requester MAC, sampled on accepted start.
REQ-007 SHALL have port tpa  input  32  requester IPv4, sampled on accepted start.
REQ-008 SHALL have port ready  input  1  downstream accepts current nibble.
REQ-009 SHALL have port dout  output  4  payload nibble.
REQ-010 SHALL have port dout_valid  output  1  dout holds a valid nibble.
REQ-011 SHALL have port busy  output  1  high while a reply is in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse after last nibble accepted.

Function
REQ-013 SHALL implement FSM states IDLE and SEND; all outputs registered.
REQ-014 SHALL accept start only in IDLE; start in SEND is ignored, with no queuing and no effect on the latched tha/tpa.
REQ-015 On accepted start in cycle N, SHALL latch tha/tpa, enter SEND, and present nibble index 0 with dout_valid=1 and busy=1 in cycle N+1.
REQ-016 SHALL emit exactly 56 nibbles (28 bytes), index 0..55, most-significant nibble of each field first.
REQ-017 Nibble map: 0-3 = 0,0,0,1 (HTYPE 0x0001); 4-7 = 0,8,0,0 (PTYPE 0x0800); 8-9 = 0,6 (HLEN); 10-11 = 0,4 (PLEN); 12-15 = 0,0,0,2 (OPER reply).
REQ-018 Nibble map: 16-27 = LOCAL_MAC; 28-35 = LOCAL_IP; 36-47 = latched tha; 48-55 = latched tpa.
REQ-019 SHALL advance the 6-bit index only on a cycle with dout_valid && ready; with ready low, dout and index SHALL hold unchanged.
REQ-020 When the handshake occurs at index 55: next cycle SHALL be IDLE with dout_valid=0, busy=0, done=1 for exactly one cycle.
REQ-021 start in the done cycle SHALL be accepted (back-to-back replies), with first nibble of the new reply the following cycle.
REQ-022 In IDLE, dout SHALL be 4'h0 and dout_valid 0; ready is ignored.
REQ-023 The index SHALL never wrap past 55; no nibble beyond index 55 SHALL be emitted.
REQ-024 Changes on tha/tpa after start SHALL NOT affect the frame in progress.

Reset
REQ-025 rst SHALL force IDLE, index=0, dout=4'h0, dout_valid=0, busy=0, done=0, and latched tha/tpa=0.
REQ-026 rst asserted mid-SEND SHALL abort the frame with no done pulse; start in the same cycle as rst SHALL be ignored.
REQ-027 First start after rst release SHALL produce a complete frame starting at index 0.

Verification
REQ-028 ready=1 constantly; start with tha=48'hAABBCCDDEEFF and tpa=32'hC0A80101 -> 56 consecutive valid nibbles 0,0,0,1,0,8,0,0,0,6,0,4,0,0,0,2,0,2,0,0,0,0,0,0,0,0,0,1,C,0,A,8,0,1,6,4,A,A,B,B,C,C,D,D,E,E,F,F,C,0,A,8,0,1,0,1, then done=1 one cycle.
REQ-029 Same request with ready toggled pseudo-randomly -> identical nibble sequence at handshake points; dout stable while ready=0.
REQ-030 start re-pulsed at index 20 with different tha/tpa -> ignored; frame completes with the original values.
REQ-031 rst pulsed at index 30 -> dout_valid=0 next cycle, no done pulse; a new start then yields a full 56-nibble frame.
REQ-032 start asserted in the done cycle -> second frame begins the next cycle, no idle gap beyond the done cycle.
REQ-033 Loopback dout/dout_valid into the existing ARP receive decoder, with OPER forced to 1 -> decoder reports sha=LOCAL_MAC and spa=LOCAL_IP with no error.
